// File: rtl/mac4x16_seq_if.sv
// Handshake/bus bundle between the accumulation sequencer and its environment:
// job command, operand stream, both MAC handshakes and the result channel.
interface mac4x16_seq_if #(
  parameter int unsigned CNT_W = 16
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [CNT_W-1:0] cmd_len;
  logic             cmd_signed;
  logic [3:0]       cmd_mask;
  logic [127:0]     cmd_init;

  logic             op_valid;
  logic             op_ready;
  logic [63:0]      op_a;
  logic [63:0]      op_b;

  logic             mac_in_valid;
  logic             mac_in_ready;
  logic [63:0]      mac_a_vec;
  logic [63:0]      mac_b_vec;
  logic [127:0]     mac_c_vec;
  logic [3:0]       mac_lane_mask;
  logic             mac_op_signed;
  logic             mac_out_valid;
  logic             mac_out_ready;
  logic [127:0]     mac_y_vec;

  logic             res_valid;
  logic             res_ready;
  logic [127:0]     res_vec;

  // sequencer side
  modport slave (
    input  cmd_valid, cmd_len, cmd_signed, cmd_mask, cmd_init,
    output cmd_ready,
    input  op_valid, op_a, op_b,
    output op_ready,
    output mac_in_valid, mac_a_vec, mac_b_vec, mac_c_vec, mac_lane_mask, mac_op_signed,
    input  mac_in_ready,
    input  mac_out_valid, mac_y_vec,
    output mac_out_ready,
    output res_valid, res_vec,
    input  res_ready
  );

  // environment side: job/operand source, MAC array and result consumer
  modport master (
    output cmd_valid, cmd_len, cmd_signed, cmd_mask, cmd_init,
    input  cmd_ready,
    output op_valid, op_a, op_b,
    input  op_ready,
    input  mac_in_valid, mac_a_vec, mac_b_vec, mac_c_vec, mac_lane_mask, mac_op_signed,
    output mac_in_ready,
    output mac_out_valid, mac_y_vec,
    input  mac_out_ready,
    input  res_valid, res_vec,
    output res_ready
  );
endinterface

// File: rtl/mac4x16_seq.sv
// Accumulation sequencer for the 4-lane 16x16+32 MAC: streams N operand beats
// through the MAC, feeding each y_vec back as the next c_vec, then returns the sum.
module mac4x16_seq #(
  parameter int unsigned CNT_W = 16
) (
  input logic          clk,
  input logic          rst,
  mac4x16_seq_if.slave bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_SEND  = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]       state;
  logic [127:0]     acc;
  logic [CNT_W-1:0] rem;
  logic [63:0]      a_q;
  logic [63:0]      b_q;
  logic [3:0]       mask_q;
  logic             signed_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_IDLE;
      acc      <= '0;
      rem      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      mask_q   <= '0;
      signed_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            mask_q   <= bus.cmd_mask;
            signed_q <= bus.cmd_signed;
            acc      <= bus.cmd_init;
            rem      <= bus.cmd_len;
            state    <= (bus.cmd_len == '0) ? S_DONE : S_FETCH;
          end
        end
        S_FETCH: begin
          if (bus.op_valid) begin
            a_q   <= bus.op_a;
            b_q   <= bus.op_b;
            state <= S_SEND;
          end
        end
        S_SEND: begin
          if (bus.mac_in_ready) state <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.mac_out_valid) begin
            // masked-off lanes keep their accumulator whatever the MAC returns
            for (int unsigned i = 0; i < 4; i++) begin
              if (mask_q[i]) acc[32*i +: 32] <= bus.mac_y_vec[32*i +: 32];
            end
            rem   <= rem - 1'b1;
            state <= (rem == CNT_W'(1)) ? S_DONE : S_FETCH;
          end
        end
        S_DONE: begin
          if (bus.res_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // cmd_ready is gated by rst so it stays low for every cycle reset is held
  assign bus.cmd_ready     = rst && (state == S_IDLE);
  assign bus.op_ready      = (state == S_FETCH);
  assign bus.mac_in_valid  = (state == S_SEND);
  assign bus.mac_out_ready = (state == S_WAIT);
  assign bus.res_valid     = (state == S_DONE);

  assign bus.mac_a_vec     = a_q;
  assign bus.mac_b_vec     = b_q;
  assign bus.mac_c_vec     = acc;
  assign bus.mac_lane_mask = mask_q;
  assign bus.mac_op_signed = signed_q;
  assign bus.res_vec       = acc;

endmodule

// File: tb/tb_mac4x16_seq.sv
// Randomized bench for mac4x16_seq: job-level reference model, reactive MAC model
// with configurable backpressure, and a per-cycle compare process.
module tb_mac4x16_seq;

  // narrow counter so the maximum job length (2^CNT_W-1) fits in a short run
  localparam int unsigned CW = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mac4x16_seq_if #(.CNT_W(CW)) bus ();
  mac4x16_seq #(.CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [CW-1:0] len;
    logic          sgn;
    logic [3:0]    mask;
    logic [127:0]  init;
  } job_t;

  typedef struct {
    logic [63:0]  a;
    logic [63:0]  b;
    logic [127:0] c;
    logic [3:0]   mask;
    logic         sgn;
  } beat_t;

  int n_checks = 0;
  int n_fail   = 0;

  job_t         cmd_q[$];
  logic [63:0]  opa_q[$];
  logic [63:0]  opb_q[$];
  beat_t        beat_q[$];
  logic [127:0] res_q[$];
  logic [127:0] c_log[$];
  logic [63:0]  ja[$];
  logic [63:0]  jb[$];

  int tot_op = 0, tot_min = 0, tot_res = 0;
  logic [127:0] last_res = '0;

  // environment state
  bit d_cmd_hs, d_op_hs, d_min_hs, d_mout_hs, d_res_hs;
  logic [63:0]  cap_a, cap_b;
  logic [127:0] cap_c;
  logic [3:0]   cap_mask;
  logic         cap_sgn;
  bit busy = 0;
  int dly = 0, stall = 0, rstall = 0;
  logic [127:0] y_pend;
  int in_cfg = 0, out_cfg = 0, res_cfg = 0;
  bit rnd_bp = 0;
  int rst_req = 3;

  function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endfunction

  function automatic logic [31:0] lane_prod(input logic [15:0] a, input logic [15:0] b, input logic sgn);
    logic signed [31:0] sp;
    logic [31:0]        up;
    sp = $signed(a) * $signed(b);
    up = {16'h0, a} * {16'h0, b};
    if (sgn) return sp;
    return up;
  endfunction

  // MAC array behaviour: y = a*b + c per enabled lane, junk on disabled lanes
  function automatic logic [127:0] mac_calc(input logic [63:0] a, input logic [63:0] b,
                                            input logic [127:0] c, input logic [3:0] m, input logic s);
    logic [127:0] y;
    for (int l = 0; l < 4; l++) begin
      if (m[l]) y[32*l +: 32] = c[32*l +: 32] + lane_prod(a[16*l +: 16], b[16*l +: 16], s);
      else      y[32*l +: 32] = $urandom;
    end
    return y;
  endfunction

  // job-level reference: expected c per beat and the final accumulator
  task automatic add_job(input logic [CW-1:0] len, input logic sgn, input logic [3:0] mask,
                         input logic [127:0] init);
    job_t         j;
    beat_t        bt;
    logic [127:0] acc;
    acc    = init;
    j.len  = len;
    j.sgn  = sgn;
    j.mask = mask;
    j.init = init;
    cmd_q.push_back(j);
    for (int k = 0; k < int'(len); k++) begin
      opa_q.push_back(ja[k]);
      opb_q.push_back(jb[k]);
      bt.a = ja[k]; bt.b = jb[k]; bt.c = acc; bt.mask = mask; bt.sgn = sgn;
      beat_q.push_back(bt);
      for (int l = 0; l < 4; l++)
        if (mask[l]) acc[32*l +: 32] = acc[32*l +: 32] + lane_prod(ja[k][16*l +: 16], jb[k][16*l +: 16], sgn);
    end
    res_q.push_back(acc);
  endtask

  task automatic fill_const(input logic [63:0] a, input logic [63:0] b, input int n);
    ja.delete(); jb.delete();
    for (int k = 0; k < n; k++) begin ja.push_back(a); jb.push_back(b); end
  endtask

  task automatic fill_rand(input int n);
    ja.delete(); jb.delete();
    for (int k = 0; k < n; k++) begin
      ja.push_back({$urandom, $urandom});
      jb.push_back({$urandom, $urandom});
    end
  endtask

  task automatic set_bp(input int i_s, input int o_d, input int r_s, input bit rnd);
    in_cfg = i_s; out_cfg = o_d; res_cfg = r_s; rnd_bp = rnd;
    stall = i_s; rstall = r_s;
  endtask

  function automatic void flush_tb();
    cmd_q.delete(); opa_q.delete(); opb_q.delete(); beat_q.delete(); res_q.delete();
    busy = 0; dly = 0; stall = in_cfg; rstall = res_cfg;
    bus.cmd_valid = 1'b0; bus.op_valid = 1'b0; bus.mac_in_ready = 1'b0;
    bus.mac_out_valid = 1'b0; bus.res_ready = 1'b0;
  endfunction

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while ((cmd_q.size() != 0 || res_q.size() != 0) && n < 4000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 4000) begin
      n_checks++; n_fail++;
      $display("FAIL %s_timeout: %0d results still pending, required 0", tag, res_q.size());
    end
    @(negedge clk);
  endtask

  // environment driver: samples handshakes mid-cycle, updates inputs 1ns after the edge
  initial begin : driver
    bus.cmd_len = '0; bus.cmd_signed = 1'b0; bus.cmd_mask = '0; bus.cmd_init = '0;
    bus.op_a = '0; bus.op_b = '0; bus.mac_y_vec = '0;
    flush_tb();
    forever begin
      @(negedge clk);
      d_cmd_hs  = rst && bus.cmd_valid && bus.cmd_ready;
      d_op_hs   = rst && bus.op_valid && bus.op_ready;
      d_min_hs  = rst && bus.mac_in_valid && bus.mac_in_ready;
      d_mout_hs = rst && bus.mac_out_valid && bus.mac_out_ready;
      d_res_hs  = rst && bus.res_valid && bus.res_ready;
      cap_a = bus.mac_a_vec; cap_b = bus.mac_b_vec; cap_c = bus.mac_c_vec;
      cap_mask = bus.mac_lane_mask; cap_sgn = bus.mac_op_signed;
      @(posedge clk);
      #1;
      if (rst_req > 0) begin
        rst = 1'b0;
        rst_req--;
        flush_tb();
      end else begin
        rst = 1'b1;
        if (d_cmd_hs && cmd_q.size() > 0) void'(cmd_q.pop_front());
        bus.cmd_valid = (cmd_q.size() > 0);
        if (cmd_q.size() > 0) begin
          bus.cmd_len = cmd_q[0].len; bus.cmd_signed = cmd_q[0].sgn;
          bus.cmd_mask = cmd_q[0].mask; bus.cmd_init = cmd_q[0].init;
        end
        if (d_op_hs && opa_q.size() > 0) begin
          void'(opa_q.pop_front());
          void'(opb_q.pop_front());
        end
        if (!(bus.op_valid && !d_op_hs))
          bus.op_valid = (opa_q.size() > 0) && ($urandom_range(0, 3) != 0);
        if (bus.op_valid) begin bus.op_a = opa_q[0]; bus.op_b = opb_q[0]; end
        if (d_min_hs) begin
          busy   = 1;
          y_pend = mac_calc(cap_a, cap_b, cap_c, cap_mask, cap_sgn);
          dly    = rnd_bp ? int'($urandom_range(0, 3)) : out_cfg;
          stall  = rnd_bp ? int'($urandom_range(0, 3)) : in_cfg;
        end
        if (busy) bus.mac_in_ready = 1'b0;
        else if (bus.mac_in_valid) begin
          if (stall > 0) begin stall--; bus.mac_in_ready = 1'b0; end
          else bus.mac_in_ready = 1'b1;
        end else bus.mac_in_ready = 1'b0;
        if (d_mout_hs) begin
          busy = 0;
          bus.mac_out_valid = 1'b0;
          bus.mac_y_vec = {$urandom, $urandom, $urandom, $urandom};
        end else if (busy && !bus.mac_out_valid) begin
          if (dly > 0) dly--;
          else begin bus.mac_out_valid = 1'b1; bus.mac_y_vec = y_pend; end
        end
        if (rnd_bp) bus.res_ready = ($urandom_range(0, 2) != 0);
        else if (d_res_hs) begin bus.res_ready = 1'b0; rstall = res_cfg; end
        else if (bus.res_valid) begin
          if (rstall > 0) begin rstall--; bus.res_ready = 1'b0; end
          else bus.res_ready = 1'b1;
        end else bus.res_ready = 1'b0;
      end
    end
  end

  // compare process
  bit rst_low_prev = 0, pend_res = 0, prev_min_open = 0, prev_res_open = 0;
  int cur_len = 0, cur_rem = 0, in_cnt = 0;
  logic [127:0] prev_ab, prev_c, prev_res;
  logic [4:0]   prev_ctl;

  always @(negedge clk) begin : compare
    logic cmd_hs, op_hs, min_hs, mout_hs, res_hs;
    beat_t bt;
    logic [127:0] er;
    if (!rst) begin
      chk("cmd_ready_in_reset", 128'(bus.cmd_ready), 128'(0));
      if (rst_low_prev) begin
        chk("reset_op_ready", 128'(bus.op_ready), 128'(0));
        chk("reset_mac_in_valid", 128'(bus.mac_in_valid), 128'(0));
        chk("reset_mac_out_ready", 128'(bus.mac_out_ready), 128'(0));
        chk("reset_res_valid", 128'(bus.res_valid), 128'(0));
        chk("reset_acc", bus.res_vec, 128'(0));
        chk("reset_operands", {bus.mac_a_vec, bus.mac_b_vec}, 128'(0));
      end
      rst_low_prev = 1; pend_res = 0; cur_len = 0; cur_rem = 0; in_cnt = 0;
      prev_min_open = 0; prev_res_open = 0;
    end else begin
      if (rst_low_prev) begin
        chk("release_cmd_ready", 128'(bus.cmd_ready), 128'(1));
        chk("release_acc", bus.res_vec, 128'(0));
        chk("release_mac_c", bus.mac_c_vec, 128'(0));
        chk("release_ctl", 128'({bus.mac_lane_mask, bus.mac_op_signed}), 128'(0));
      end
      rst_low_prev = 0;
      chk("one_active_strobe", 128'($countones({bus.cmd_ready, bus.op_ready, bus.mac_in_valid,
                                                 bus.mac_out_ready, bus.res_valid})), 128'(1));
      if (prev_min_open) begin
        chk("mac_in_valid_held", 128'(bus.mac_in_valid), 128'(1));
        chk("mac_ab_stable", {bus.mac_a_vec, bus.mac_b_vec}, prev_ab);
        chk("mac_c_stable", bus.mac_c_vec, prev_c);
        chk("mac_ctl_stable", 128'({bus.mac_lane_mask, bus.mac_op_signed}), 128'(prev_ctl));
      end
      if (prev_res_open) begin
        chk("res_valid_held", 128'(bus.res_valid), 128'(1));
        chk("res_vec_stable", bus.res_vec, prev_res);
      end
      if (pend_res) chk("res_valid_latency", 128'(bus.res_valid), 128'(1));
      pend_res = 0;
      cmd_hs  = bus.cmd_valid && bus.cmd_ready;
      op_hs   = bus.op_valid && bus.op_ready;
      min_hs  = bus.mac_in_valid && bus.mac_in_ready;
      mout_hs = bus.mac_out_valid && bus.mac_out_ready;
      res_hs  = bus.res_valid && bus.res_ready;
      if (cmd_hs) begin
        cur_len = int'(bus.cmd_len); cur_rem = cur_len; in_cnt = 0;
        if (cur_len == 0) pend_res = 1;
      end
      if (op_hs) tot_op++;
      if (min_hs) begin
        tot_min++; in_cnt++;
        c_log.push_back(bus.mac_c_vec);
        if (beat_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_mac_beat: got a mac_in transfer, required none");
        end else begin
          bt = beat_q.pop_front();
          chk("mac_a_vec", 128'(bus.mac_a_vec), 128'(bt.a));
          chk("mac_b_vec", 128'(bus.mac_b_vec), 128'(bt.b));
          chk("mac_c_vec", bus.mac_c_vec, bt.c);
          chk("mac_ctl", 128'({bus.mac_lane_mask, bus.mac_op_signed}), 128'({bt.mask, bt.sgn}));
        end
      end
      if (mout_hs) begin
        cur_rem--;
        if (cur_rem == 0) pend_res = 1;
      end
      if (res_hs) begin
        tot_res++;
        last_res = bus.res_vec;
        chk("beats_per_job", 128'(in_cnt), 128'(cur_len));
        if (res_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_result: got %h, required no result", bus.res_vec);
        end else begin
          er = res_q.pop_front();
          chk("res_vec", bus.res_vec, er);
        end
      end
      prev_min_open = bus.mac_in_valid && !min_hs;
      prev_res_open = bus.res_valid && !res_hs;
      prev_ab  = {bus.mac_a_vec, bus.mac_b_vec};
      prev_c   = bus.mac_c_vec;
      prev_ctl = {bus.mac_lane_mask, bus.mac_op_signed};
      prev_res = bus.res_vec;
    end
  end

  initial begin : main
    int s0, s1, n;
    logic [127:0] init;
    set_bp(0, 0, 0, 0);
    n = 0;
    while (!rst && n < 100) begin @(negedge clk); n++; end
    @(negedge clk);

    // unsigned single beat: 3*5 on every lane
    fill_const(64'h0003_0003_0003_0003, 64'h0005_0005_0005_0005, 1);
    s0 = tot_min;
    add_job(CW'(1), 1'b0, 4'hF, '0);
    wait_idle("single");
    chk("single_mac_transfers", 128'(tot_min - s0), 128'(1));
    chk("single_res", last_res, {4{32'h0000_000F}});

    // signed chain: lane0 10 -> 2 -> -6 -> -14
    c_log.delete();
    fill_const(64'hFFFE_FFFE_FFFE_FFFE, 64'h0004_0004_0004_0004, 3);
    add_job(CW'(3), 1'b1, 4'hF, {96'h0, 32'd10});
    wait_idle("chain");
    chk("chain_c_count", 128'(c_log.size()), 128'(3));
    if (c_log.size() >= 3) begin
      chk("chain_c0", 128'(c_log[0][31:0]), 128'(32'd10));
      chk("chain_c1", 128'(c_log[1][31:0]), 128'(32'd2));
      chk("chain_c2", 128'(c_log[2][31:0]), 128'(32'hFFFF_FFFA));
    end
    chk("chain_res_lane0", 128'(last_res[31:0]), 128'(32'hFFFF_FFF2));

    // zero length: result is the initial accumulator, no operand or MAC traffic
    init = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;
    s0 = tot_min; s1 = tot_op;
    add_job(CW'(0), 1'b0, 4'hF, init);
    wait_idle("zero");
    chk("zero_mac_transfers", 128'(tot_min - s0), 128'(0));
    chk("zero_op_transfers", 128'(tot_op - s1), 128'(0));
    chk("zero_res", last_res, init);

    // lane mask 0101 with junk from the MAC on lanes 1 and 3
    fill_const(64'h0001_0001_0001_0001, 64'h0001_0001_0001_0001, 2);
    add_job(CW'(2), 1'b0, 4'b0101, {32'd4, 32'd3, 32'd2, 32'd1});
    wait_idle("mask");
    chk("mask_res", last_res, {32'd4, 32'd5, 32'd2, 32'd3});

    // backpressure on every handshake
    set_bp(5, 4, 3, 0);
    fill_rand(4);
    s0 = tot_min;
    add_job(CW'(4), 1'($urandom), 4'($urandom), {$urandom, $urandom, $urandom, $urandom});
    wait_idle("backpressure");
    chk("bp_mac_transfers", 128'(tot_min - s0), 128'(4));

    // reset while the MAC result is outstanding
    set_bp(0, 6, 0, 0);
    fill_rand(2);
    s0 = tot_res;
    add_job(CW'(2), 1'b0, 4'hF, {$urandom, $urandom, $urandom, $urandom});
    n = 0;
    while (!bus.mac_out_ready && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) begin
      n_checks++; n_fail++;
      $display("FAIL reach_wait_timeout: mac_out_ready got 0, required 1");
    end
    rst_req = 1;
    n = 0;
    while (rst && n < 10) begin @(negedge clk); n++; end
    n = 0;
    while (!rst && n < 10) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    chk("reset_discards_result", 128'(tot_res - s0), 128'(0));
    set_bp(0, 0, 0, 0);
    fill_const(64'h0007_0007_0007_0007, 64'h0006_0006_0006_0006, 1);
    add_job(CW'(1), 1'b0, 4'hF, '0);
    wait_idle("after_reset");
    chk("after_reset_res", last_res, {4{32'h0000_002A}});

    // maximum job length for the counter width
    fill_rand(15);
    s0 = tot_min;
    add_job(CW'(15), 1'($urandom), 4'hF, {$urandom, $urandom, $urandom, $urandom});
    wait_idle("max_len");
    chk("max_len_mac_transfers", 128'(tot_min - s0), 128'(15));

    // random back-to-back jobs with random backpressure
    set_bp(0, 0, 0, 1);
    for (int b = 0; b < 5; b++) begin
      for (int j = 0; j < 5; j++) begin
        n = int'($urandom_range(0, 6));
        fill_rand(n);
        add_job(CW'(n), 1'($urandom), 4'($urandom), {$urandom, $urandom, $urandom, $urandom});
      end
      wait_idle("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation still running at %0t, required finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
